// File: rtl/btn_bcd_counter.sv
// btn_bcd_counter: push-button front end for the four-digit display.
// Synchronises and debounces the raw button, turns presses (and long holds)
// into increment strobes, and keeps a 4-digit packed-BCD count for the
// seven-segment scanner. Digit 3 is count[15:12], digit 0 is count[3:0].
//
// FSM states:
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_RELEASED | button up; a rising btn_stable increments and enters HELD
//   ST_HELD     | first increment done; timing the hold-off before repeat
//   ST_REPEAT   | auto-repeat; one increment every REPEAT_CYCLES cycles
module btn_bcd_counter #(
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic        clr,
    output logic [15:0] count,
    output logic        inc_pulse,
    output logic        btn_stable
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    // Raw pin level while the button is up; synchroniser resets to it so no
    // phantom press is seen coming out of reset.
    localparam logic RELEASED_LVL = (BTN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_HELD     = 2'd1,
        ST_REPEAT   = 2'd2
    } state_t;

    logic             sync_q1;
    logic             sync_q2;
    logic             btn_s;
    logic [DB_W-1:0]  db_cnt;
    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_nxt;
    logic             inc_req;

    // Packed-BCD +1 with ripple carry; 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[4*d +: 4] >= 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser on the asynchronous button pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= RELEASED_LVL;
            sync_q2 <= RELEASED_LVL;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

    // Polarity-normalised synchronised level, 1 = pressed.
    assign btn_s = sync_q2 ^ RELEASED_LVL;

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt     <= '0;
            btn_stable <= 1'b0;
        end else if (btn_s == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt     <= '0;
            btn_stable <= ~btn_stable;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // FSM state and hold/repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RELEASED;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state logic; release always wins over a timer expiry.
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        inc_req   = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (btn_stable) begin
                    inc_req   = 1'b1;
                    state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!btn_stable) begin
                    state_nxt = ST_RELEASED;
                end else if (timer == HOLD_LAST) begin
                    inc_req   = 1'b1;
                    state_nxt = ST_REPEAT;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!btn_stable) begin
                    state_nxt = ST_RELEASED;
                end else if (timer == REP_LAST) begin
                    inc_req = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
            end
        endcase
    end

    // Count register and strobe; clr overrides a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 16'h0000;
            inc_pulse <= 1'b0;
        end else if (clr) begin
            count     <= 16'h0000;
            inc_pulse <= 1'b0;
        end else if (inc_req) begin
            count     <= bcd_inc(count);
            inc_pulse <= 1'b1;
        end else begin
            inc_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_bcd_counter.sv
// Testbench for btn_bcd_counter.
// Instance "a": active-low button, DEBOUNCE=4, HOLD=50, REPEAT=10.
// Instance "w": active-high button, DEBOUNCE=2, HOLD=2, REPEAT=2, held down
// long enough to walk the count through 0999->1000 and 9999->0000.
module tb_btn_bcd_counter;

    logic        clk;
    logic        rst_a, btn_a, clr_a;
    logic [15:0] count_a;
    logic        inc_a, stable_a;
    logic        rst_w, btn_w, clr_w;
    logic [15:0] count_w;
    logic        inc_w, stable_w;

    int n_checks = 0;
    int n_errors = 0;

    btn_bcd_counter #(
        .BTN_ACTIVE_LOW (1),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (50),
        .REPEAT_CYCLES  (10)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .btn       (btn_a),
        .clr       (clr_a),
        .count     (count_a),
        .inc_pulse (inc_a),
        .btn_stable(stable_a)
    );

    btn_bcd_counter #(
        .BTN_ACTIVE_LOW (0),
        .DEBOUNCE_CYCLES(2),
        .HOLD_CYCLES    (2),
        .REPEAT_CYCLES  (2)
    ) u_dut_w (
        .clk       (clk),
        .rst       (rst_w),
        .btn       (btn_w),
        .clr       (clr_w),
        .count     (count_w),
        .inc_pulse (inc_w),
        .btn_stable(stable_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pressed;
        int          cycles;
        int          exp_pulses;
        int          exp_lat;
        logic [15:0] exp_count;
        logic        exp_stable;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release_a();
        btn_a = 1'b0;
        repeat (12) tick();
        btn_a = 1'b1;
        repeat (12) tick();
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [15:0] v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
    endfunction

    initial begin
        int          pulses;
        int          lat;
        int          n;
        int          offs[$];
        int          exp_offs[6];
        int          model;
        int          incs;
        logic [15:0] prev;

        rst_a = 1'b1; btn_a = 1'b1; clr_a = 1'b0;
        rst_w = 1'b1; btn_w = 1'b0; clr_w = 1'b0;

        // Vector table: drive level, run cycles, expect pulses/latency/count/stable.
        vecs.push_back('{1'b1, 20, 1, 7, 16'h0001, 1'b1});
        vecs.push_back('{1'b0, 20, 0, -1, 16'h0001, 1'b0});
        for (int g = 0; g < 10; g++) begin
            vecs.push_back('{1'b1, 3, 0, -1, 16'h0001, 1'b0});
            vecs.push_back('{1'b0, 3, 0, -1, 16'h0001, 1'b0});
        end
        vecs.push_back('{1'b0, 10, 0, -1, 16'h0001, 1'b0});

        // Reset and idle.
        repeat (3) tick();
        check("rst_count", 32'(count_a), 32'h0);
        check("rst_inc", 32'(inc_a), 32'h0);
        check("rst_stable", 32'(stable_a), 32'h0);
        rst_a  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (inc_a) pulses++;
        end
        check("idle_pulses", 32'(pulses), 32'h0);
        check("idle_count", 32'(count_a), 32'h0);
        check("idle_stable", 32'(stable_a), 32'h0);

        // Table-driven single press, release and glitch rejection.
        for (int i = 0; i < vecs.size(); i++) begin
            btn_a  = ~vecs[i].pressed;
            pulses = 0;
            lat    = -1;
            for (int c = 1; c <= vecs[i].cycles; c++) begin
                tick();
                if (inc_a) begin
                    pulses++;
                    if (lat < 0) lat = c;
                end
            end
            check($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_count", i), 32'(count_a), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_stable", i), 32'(stable_a), 32'(vecs[i].exp_stable));
        end

        // Auto-repeat: btn_stable high for exactly 100 cycles.
        rst_a = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0;
        tick();
        btn_a = 1'b0;
        n = 0;
        while (!stable_a && n < 20) begin
            tick();
            n++;
        end
        check("ar_debounce_edges", 32'(n), 32'd6);
        exp_offs = '{1, 51, 61, 71, 81, 91};
        for (int off = 1; off <= 120; off++) begin
            tick();
            if (inc_a) offs.push_back(off);
            if (off == 94) btn_a = 1'b1;
        end
        check("ar_pulse_total", 32'(offs.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ar_pulse%0d_offset", i), 32'((i < offs.size()) ? offs[i] : -1), 32'(exp_offs[i]));
        end
        check("ar_count", 32'(count_a), 32'h0006);
        check("ar_stable_after", 32'(stable_a), 32'h0);

        // Presses up to 0009, then the digit-0 carry.
        repeat (3) press_release_a();
        check("press_to_0009", 32'(count_a), 32'h0009);
        press_release_a();
        check("carry_0010", 32'(count_a), 32'h0010);

        // clr coinciding with a repeat increment.
        btn_a = 1'b0;
        n = 0;
        while (!stable_a && n < 20) begin
            tick();
            n++;
        end
        check("clr_stable_rise", 32'(stable_a), 32'h1);
        repeat (60) tick();
        check("clr_pre_count", 32'(count_a), 32'h0012);
        clr_a = 1'b1;
        tick();
        check("clr_coll_count", 32'(count_a), 32'h0000);
        check("clr_coll_inc", 32'(inc_a), 32'h0);
        clr_a = 1'b0;
        repeat (10) tick();
        check("clr_next_inc", 32'(inc_a), 32'h1);
        check("clr_next_count", 32'(count_a), 32'h0001);

        // rst mid-REPEAT with the button still held.
        repeat (4) tick();
        rst_a = 1'b1;
        repeat (3) tick();
        check("rst_mid_count", 32'(count_a), 32'h0);
        check("rst_mid_stable", 32'(stable_a), 32'h0);
        check("rst_mid_inc", 32'(inc_a), 32'h0);
        rst_a  = 1'b0;
        pulses = 0;
        lat    = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (inc_a) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        check("rst_mid_pulses", 32'(pulses), 32'd1);
        check("rst_mid_latency", 32'(lat), 32'd7);
        check("rst_mid_after_count", 32'(count_a), 32'h0001);
        btn_a = 1'b1;
        repeat (12) tick();

        // Fast instance: walk through every value and both high carries.
        rst_w = 1'b0;
        tick();
        btn_w = 1'b1;
        model = 0;
        incs  = 0;
        lat   = -1;
        prev  = count_w;
        for (int c = 1; c <= 25000 && incs < 10001 && n_errors < 100; c++) begin
            tick();
            if (inc_w) begin
                incs++;
                model = (model + 1) % 10000;
                if (lat < 0) begin
                    lat = c;
                    check("w_first_latency", 32'(lat), 32'd5);
                    check("w_stable_at_first", 32'(stable_w), 32'h1);
                end
                if (model == 1000) begin
                    check("w_prev_0999", 32'(prev), 32'h0999);
                    check("w_carry_1000", 32'(count_w), 32'h1000);
                end
                if (model == 0) begin
                    check("w_prev_9999", 32'(prev), 32'h9999);
                    check("w_wrap_0000", 32'(count_w), 32'h0000);
                end
            end
            check("w_count_track", 32'(count_w), 32'(to_bcd(model)));
            check("w_nibbles", 32'(nibbles_ok(count_w)), 32'h1);
            prev = count_w;
        end
        check("w_total_incs", 32'(incs), 32'd10001);
        check("w_final_count", 32'(count_w), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
